// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Data-bus bundle (req/gnt/rvalid) between mem_stage and memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : RV32I memory-access stage with lane steering, load extension,
//                optional bus timeout and MEM_MISALIGN_TRAP_EN misalign trap.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] opr_res,
    input  logic [31:0] rs2_data,
    input  logic [31:0] csr_rdata,
    input  logic [4:0]  rd,
    input  logic [31:0] pc4,
    input  logic        rf_en,
    input  logic [1:0]  wb_sel,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        mem_uns,
    output logic        mem_stall,
    output logic        bus_err,
    mem_stage_if.master dbus,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic        wb_valid,
    output logic [31:0] wb_opr_res,
    output logic [31:0] wb_lsu_rdata,
    output logic [31:0] wb_csr_rdata,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_pc4,
    output logic        wb_rf_en,
    output logic [1:0]  wb_wb_sel
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam bit         c_tmo_en   = (BUS_TIMEOUT != 0);
    localparam logic [7:0] c_tmo_last = 8'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [7:0]  r_tmo_cnt;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_access;
    logic        w_done;
    logic        w_timeout;
    logic        w_tmo_hit;
    logic [1:0]  w_off;
    logic [31:0] w_shift;
    logic [31:0] w_load_data;

    // Reset gates the request so an access in flight is dropped immediately.
    assign w_is_mem = in_valid & (mem_rd | mem_wr) & ~rst;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = w_is_mem &
                          ((mem_size == 2'b01 & opr_res[0]) |
                           (mem_size[1] & (opr_res[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_access = w_is_mem & ~w_misaligned;

    always_comb begin
        if (mem_size[1])      w_off = 2'b00;
        else if (mem_size[0]) w_off = {opr_res[1], 1'b0};
        else                  w_off = opr_res[1:0];
    end

    assign dbus.dbus_we    = mem_wr;
    assign dbus.dbus_addr  = {opr_res[31:2], 2'b00};

    always_comb begin
        dbus.dbus_be    = 4'hF;
        dbus.dbus_wdata = rs2_data;
        if (!mem_size[1]) begin
            if (mem_size[0]) begin
                dbus.dbus_be    = 4'b0011 << w_off;
                dbus.dbus_wdata = {2{rs2_data[15:0]}};
            end else begin
                dbus.dbus_be    = 4'b0001 << w_off;
                dbus.dbus_wdata = {4{rs2_data[7:0]}};
            end
        end
    end

    assign w_shift = dbus.dbus_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load_data = w_shift;
        if (!mem_size[1]) begin
            if (mem_size[0]) w_load_data = {{16{~mem_uns & w_shift[15]}}, w_shift[15:0]};
            else             w_load_data = {{24{~mem_uns & w_shift[7]}},  w_shift[7:0]};
        end
    end

    assign w_tmo_hit = c_tmo_en && (r_tmo_cnt == c_tmo_last);

    always_comb begin
        w_state_next  = r_state;
        dbus.dbus_req = 1'b0;
        w_done        = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    dbus.dbus_req = 1'b1;
                    if (dbus.dbus_gnt) begin
                        if (mem_wr) w_done       = 1'b1;
                        else        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                dbus.dbus_req = 1'b1;
                if (dbus.dbus_gnt) begin
                    if (mem_wr) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_RESP;
                    end
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_RESP: begin
                if (dbus.dbus_rvalid) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign mem_stall = w_access & ~w_done & ~w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Counter restarts on every state entry, so REQ and RESP are timed separately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              r_tmo_cnt <= 8'd0;
        else if (r_state == S_IDLE || w_state_next != r_state) r_tmo_cnt <= 8'd0;
        else                                                  r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_rf_en     <= 1'b0;
            wb_opr_res   <= 32'd0;
            wb_lsu_rdata <= 32'd0;
            wb_csr_rdata <= 32'd0;
            wb_rd        <= 5'd0;
            wb_pc4       <= 32'd0;
            wb_wb_sel    <= 2'd0;
            bus_err      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned   <= 1'b0;
`endif
        end else begin
            wb_valid     <= in_valid & ~mem_stall & ~w_timeout;
            wb_rf_en     <= rf_en & in_valid & ~mem_stall & ~w_timeout & ~w_misaligned;
            wb_opr_res   <= opr_res;
            wb_lsu_rdata <= w_load_data;
            wb_csr_rdata <= csr_rdata;
            wb_rd        <= rd;
            wb_pc4       <= pc4;
            wb_wb_sel    <= wb_sel;
            bus_err      <= w_timeout;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned   <= w_misaligned;
`endif
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline. Sits between execute and writeback.
- Performs loads and stores on a req/gnt/rvalid data bus, with byte-lane steering and sign/zero extension.
- Stalls upstream while an access is outstanding.
- Registers all writeback-stage inputs: ALU result, load data, CSR data, rd, pc4, rf_en, wb_sel.

Parameters:
- BUS_TIMEOUT, 0, cycles to wait for dbus_gnt/dbus_rvalid before aborting. 0 = never time out. Max 255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  instruction present in stage
- opr_res  in  32  ALU result; is the effective address for memory ops
- rs2_data  in  32  store data
- csr_rdata  in  32  CSR read value, passed through
- rd  in  5  destination register
- pc4  in  32  PC+4, passed through
- rf_en  in  1  register-file write enable
- wb_sel  in  2  writeback mux select, passed through
- mem_rd  in  1  load
- mem_wr  in  1  store; mem_rd and mem_wr are never both 1
- mem_size  in  2  00 byte, 01 half, 10 word
- mem_uns  in  1  zero-extend load (LBU/LHU)
- mem_stall  out  1  hold upstream stages
- bus_err  out  1  one-cycle pulse on timeout abort
- dbus_req  out  1  bus request
- dbus_we  out  1  write enable
- dbus_addr  out  32  word-aligned address ({opr_res[31:2],2'b00})
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-replicated store data
- dbus_gnt  in  1  request accepted
- dbus_rvalid  in  1  read data valid
- dbus_rdata  in  32  read data
- wb_valid, wb_opr_res, wb_lsu_rdata, wb_csr_rdata, wb_rd, wb_pc4, wb_rf_en, wb_wb_sel  out  1/32/32/32/5/32/1/2  writeback-stage input register

Behaviour:
- Reset: FSM=IDLE; all wb_* outputs, dbus_req and bus_err are 0.
- FSM states: IDLE, REQ (waiting for gnt), RESP (load waiting for rvalid).
- IDLE:
  - in_valid & (mem_rd|mem_wr) drives dbus_req=1 combinationally in the same cycle.
  - gnt=1 with a store: access complete, no stall.
  - gnt=1 with a load: go to RESP.
  - gnt=0: go to REQ.
- REQ: dbus_req and all dbus_* fields held stable until gnt. On gnt: store completes; load goes to RESP.
- RESP: dbus_req=0. On rvalid: load completes, return to IDLE.
- Earliest rvalid is the cycle after gnt; rvalid seen in IDLE/REQ is ignored.
- mem_stall = in_valid & memop & ~complete_this_cycle. Upstream holds inputs stable while mem_stall=1.
- WB register loads at every edge where mem_stall=0. wb_valid=in_valid, other fields from inputs; wb_lsu_rdata = extracted load data.
- While mem_stall=1, the WB register loads a bubble: wb_valid=0, wb_rf_en=0, other fields don't-care.
- Non-memory instructions have 1-cycle latency into the WB register.
- Store byte enables:
  - byte: be = 1<<addr[1:0]
  - half: be = 4'b0011<<addr[1:0]
  - word: be = 4'hF
- Store data: byte replicated x4; half replicated x2.
- Load extraction: shift dbus_rdata right by 8*addr[1:0], take 8/16/32 bits, then sign-extend, or zero-extend if mem_uns.
- Timeout (BUS_TIMEOUT>0):
  - An 8-bit counter counts cycles spent in REQ/RESP; it clears on state entry.
  - On reaching BUS_TIMEOUT: go to IDLE, pulse bus_err, release the stall, and write a bubble with wb_rf_en=0 for that instruction.
- Reset asserted mid-access: immediate return to IDLE with dbus_req=0. A later rvalid is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit, registered alongside wb_valid).
  - Misaligned cases: half with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned access issues no bus request and causes no stall.
  - It writes WB with wb_rf_en=0 and misaligned=1 for one cycle.
- Undefined:
  - No misaligned port.
  - Low address bits are masked as if naturally aligned: half uses addr[1]; word ignores addr[1:0].

Test Plan:
- ALU op, opr_res=0x1234, rd=5, rf_en=1 -> next cycle wb_valid=1, wb_opr_res=0x1234, wb_rd=5, mem_stall never 1.
- SB addr=0x103, rs2=0xAB, gnt same cycle -> be=4'b1000, wdata=0xABABABAB, dbus_addr=0x100, zero stall cycles.
- LH addr=0x202, gnt after 2 cycles, rvalid 1 cycle later, rdata=0x8001xxxx -> mem_stall 3 cycles, wb_lsu_rdata=0xFFFF8001. Same access as LHU -> 0x00008001.
- LW with gnt but no rvalid, BUS_TIMEOUT=4 -> bus_err pulse after 4 RESP cycles, wb_valid=0, stall released.
- rst asserted while in RESP -> dbus_req=0, wb_* =0; rvalid arriving after reset produces no WB write.
- LW addr=0x6: macro on -> misaligned=1, no dbus_req. Macro off -> dbus_addr=0x4, be=4'hF.
